// File: rtl/nr_pkg.sv
// Shared encodings and elaboration helpers for the nr_reduce_pipe radix-3 reduction tree.
package nr_pkg;

  localparam logic [2:0] NR_OR   = 3'd0;
  localparam logic [2:0] NR_NOR  = 3'd1;
  localparam logic [2:0] NR_AND  = 3'd2;
  localparam logic [2:0] NR_NAND = 3'd3;
  localparam logic [2:0] NR_XOR  = 3'd4;
  localparam logic [2:0] NR_XNOR = 3'd5;

  typedef enum logic [1:0] {OpOr, OpAnd, OpXor} nr_op_e;

  function automatic int unsigned clog3(input int unsigned n);
    int unsigned p;
    int unsigned r;
    p = 1;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (p < n) begin
        p = p * 3;
        r = r + 1;
      end
    end
    return r;
  endfunction

  function automatic int unsigned pow3(input int unsigned n);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 3;
    return p;
  endfunction

  // Reserved encodings fall through to OR so that they behave as NOR.
  function automatic nr_op_e base_op(input logic [2:0] mode);
    case (mode)
      NR_AND, NR_NAND: return OpAnd;
      NR_XOR, NR_XNOR: return OpXor;
      default:         return OpOr;
    endcase
  endfunction

  function automatic logic ident(input logic [2:0] mode);
    return base_op(mode) == OpAnd;
  endfunction

  function automatic logic is_inv(input logic [2:0] mode);
    case (mode)
      NR_OR, NR_AND, NR_XOR: return 1'b0;
      default:               return 1'b1;
    endcase
  endfunction

  function automatic logic op3(input nr_op_e op, input logic [2:0] x);
    case (op)
      OpAnd:   return &x;
      OpXor:   return ^x;
      default: return |x;
    endcase
  endfunction

endpackage

// File: rtl/nr_reduce_pipe_stage.sv
// nr_tree_stage: registers one pipeline word (data, valid, mode), then reduces it
// combinationally through LVL radix-3 levels, padding leaves with the mode's identity.
module nr_tree_stage
  import nr_pkg::*;
#(
  parameter int unsigned IN_W  = 9,
  parameter int unsigned LVL   = 1,
  parameter int unsigned OUT_W = (IN_W + pow3(LVL) - 1) / pow3(LVL)
) (
  input  logic             i_ck,
  input  logic             i_rst,
  input  logic             i_ce,
  input  logic             i_v,
  input  logic [2:0]       i_mode,
  input  logic [IN_W-1:0]  i_d,
  output logic             o_v,
  output logic [2:0]       o_mode,
  output logic [OUT_W-1:0] o_d
);

  localparam int unsigned PAD_W = OUT_W * pow3(LVL);

  // Bit offset of tree level k inside the flattened w_tree vector.
  function automatic int unsigned lvl_off(input int unsigned k);
    int unsigned s;
    s = 0;
    for (int unsigned i = 0; i < k; i++) s = s + PAD_W / pow3(i);
    return s;
  endfunction

  localparam int unsigned TOT_W = lvl_off(LVL + 1);

  logic              r_v;
  logic [2:0]        r_mode;
  logic [IN_W-1:0]   r_d;
  nr_op_e            w_op;
  logic              w_pad;
  logic [TOT_W-1:0]  w_tree;

  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      r_v <= 1'b0;
    end else if (i_ce) begin
      r_v <= i_v;
    end
    if (i_ce) begin
      r_mode <= i_mode;
      r_d    <= i_d;
    end
  end

  assign w_op  = base_op(r_mode);
  assign w_pad = ident(r_mode);

  assign w_tree[IN_W-1:0] = r_d;
  if (PAD_W > IN_W) begin : g_pad
    assign w_tree[IN_W +: (PAD_W - IN_W)] = {(PAD_W - IN_W){w_pad}};
  end

  for (genvar k = 1; k <= LVL; k++) begin : g_lvl
    localparam int unsigned LW = PAD_W / pow3(k);
    for (genvar j = 0; j < LW; j++) begin : g_node
      assign w_tree[lvl_off(k) + j] = op3(w_op, w_tree[lvl_off(k - 1) + 3 * j +: 3]);
    end
  end

  assign o_d    = w_tree[lvl_off(LVL) +: OUT_W];
  assign o_v    = r_v;
  assign o_mode = r_mode;

endmodule

// File: rtl/nr_reduce_pipe.sv
// Pipelined radix-3 OR/NOR/AND/NAND/XOR/XNOR reduction of a WIDTH-bit vector.
// Define NR_STICKY_EN to add the SCLR input and the sticky-one ZS output.
module nr_reduce_pipe
  import nr_pkg::*;
#(
  parameter int unsigned WIDTH       = 9,
  parameter int unsigned LVL_PER_STG = 1
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             CE,
  input  logic             VI,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  output logic             VO,
  output logic             Z,
  output logic             ZN
`ifdef NR_STICKY_EN
  ,
  input  logic             SCLR,
  output logic             ZS
`endif
);

  localparam int unsigned LEVELS = clog3(WIDTH);
  localparam int unsigned STAGES = (LEVELS + LVL_PER_STG - 1) / LVL_PER_STG;

  // Width of the data entering stage s; segment STAGES is the single result bit.
  function automatic int unsigned seg_w(input int unsigned s);
    return (WIDTH + pow3(LVL_PER_STG * s) - 1) / pow3(LVL_PER_STG * s);
  endfunction

  function automatic int unsigned seg_off(input int unsigned s);
    int unsigned o;
    o = 0;
    for (int unsigned i = 0; i < s; i++) o = o + seg_w(i);
    return o;
  endfunction

  localparam int unsigned BUS_W = seg_off(STAGES + 1);

  logic [BUS_W-1:0]      w_bus;
  logic [STAGES:0]       w_v;
  logic [STAGES:0][2:0]  w_mode;
  logic                  w_res;
  logic                  r_vo;
  logic                  r_z;
  logic                  r_zn;

  assign w_bus[WIDTH-1:0] = D;
  assign w_v[0]           = VI;
  assign w_mode[0]        = MODE;

  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    nr_tree_stage #(
      .IN_W  (seg_w(s)),
      .LVL   (LVL_PER_STG),
      .OUT_W (seg_w(s + 1))
    ) u_stage (
      .i_ck   (CK),
      .i_rst  (RST),
      .i_ce   (CE),
      .i_v    (w_v[s]),
      .i_mode (w_mode[s]),
      .i_d    (w_bus[seg_off(s) +: seg_w(s)]),
      .o_v    (w_v[s + 1]),
      .o_mode (w_mode[s + 1]),
      .o_d    (w_bus[seg_off(s + 1) +: seg_w(s + 1)])
    );
  end

  // Inversion uses the mode that travelled with this word, not the live MODE input.
  assign w_res = w_bus[seg_off(STAGES)] ^ is_inv(w_mode[STAGES]);

  always_ff @(posedge CK) begin
    if (RST) begin
      r_vo <= 1'b0;
      r_z  <= 1'b0;
      r_zn <= 1'b1;
    end else if (CE) begin
      r_vo <= w_v[STAGES];
      if (w_v[STAGES]) begin
        r_z  <= w_res;
        r_zn <= ~w_res;
      end
    end
  end

  assign VO = r_vo;
  assign Z  = r_z;
  assign ZN = r_zn;

`ifdef NR_STICKY_EN
  logic r_zs;

  always_ff @(posedge CK) begin
    if (RST) begin
      r_zs <= 1'b0;
    end else if (CE) begin
      if (w_v[STAGES] && w_res) begin
        r_zs <= 1'b1;
      end else if (SCLR) begin
        r_zs <= 1'b0;
      end
    end
  end

  assign ZS = r_zs;
`endif

endmodule

// File: tb/tb_nr_reduce_pipe.sv
// Scoreboard bench for nr_reduce_pipe: WIDTH=9 (latency 2) and WIDTH=10 (latency 3) side by side.
module tb_nr_reduce_pipe;

  logic       CK = 1'b0;
  logic       RST, CE, VI;
  logic [2:0] MODE;
  logic [8:0] D9;
  logic [9:0] D10;
  logic       vo9, z9, zn9, vo10, z10, zn10;
`ifdef NR_STICKY_EN
  logic       SCLR;
  logic       zs9, zs10;
`endif

  always #5 CK = ~CK;

  nr_reduce_pipe #(.WIDTH(9), .LVL_PER_STG(1)) u_dut9 (
    .CK(CK), .RST(RST), .CE(CE), .VI(VI), .MODE(MODE), .D(D9),
    .VO(vo9), .Z(z9), .ZN(zn9)
`ifdef NR_STICKY_EN
    , .SCLR(SCLR), .ZS(zs9)
`endif
  );

  nr_reduce_pipe #(.WIDTH(10), .LVL_PER_STG(1)) u_dut10 (
    .CK(CK), .RST(RST), .CE(CE), .VI(VI), .MODE(MODE), .D(D10),
    .VO(vo10), .Z(z10), .ZN(zn10)
`ifdef NR_STICKY_EN
    , .SCLR(SCLR), .ZS(zs10)
`endif
  );

  typedef struct {
    int   id;
    logic z;
    int   due;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   idxq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   ce_cnt = 0;
  int   ekind = 3;  // kind of the last edge: 0 reset, 1 CE, 2 hold, 3 none yet
  logic hvo[2], hz[2], hzn[2], zmod[2], zsmod[2];
  logic ovo[2], oz[2], ozn[2], ozs[2];
  logic exp_vo;
  logic sclr_s;

  function automatic logic model(input int w, input logic [2:0] m, input logic [9:0] d);
    logic r;
    r = (m == 3'd2 || m == 3'd3);
    for (int i = 0; i < w; i++) begin
      case (m)
        3'd2, 3'd3: r = r & d[i];
        3'd4, 3'd5: r = r ^ d[i];
        default:    r = r | d[i];
      endcase
    end
    if (m inside {3'd1, 3'd3, 3'd5, 3'd6, 3'd7}) r = ~r;
    return r;
  endfunction

  always @(posedge CK) begin
    sclr_s = 1'b0;
`ifdef NR_STICKY_EN
    sclr_s = SCLR;
`endif
    if (RST) begin
      ekind = 0;
      q.delete();
    end else if (CE) begin
      ce_cnt = ce_cnt + 1;
      ekind  = 1;
      if (VI) begin
        q.push_back('{0, model(9, MODE, {1'b0, D9}), ce_cnt + 2});
        q.push_back('{1, model(10, MODE, D10), ce_cnt + 3});
      end
    end else begin
      ekind = 2;
    end
  end

  always @(negedge CK) begin
    ovo[0] = vo9;  oz[0] = z9;  ozn[0] = zn9;
    ovo[1] = vo10; oz[1] = z10; ozn[1] = zn10;
    ozs[0] = 1'b0; ozs[1] = 1'b0;
`ifdef NR_STICKY_EN
    ozs[0] = zs9;  ozs[1] = zs10;
`endif
    for (int k = 0; k < 2; k++) begin
      if (ekind == 0) begin
        zmod[k] = 1'b0;
        zsmod[k] = 1'b0;
        n_cmp++;
        if (ovo[k] !== 1'b0 || oz[k] !== 1'b0 || ozn[k] !== 1'b1) begin
          n_err++;
          $display("FAIL reset_out dut%0d: got vo=%b z=%b zn=%b, want vo=0 z=0 zn=1",
                   k, ovo[k], oz[k], ozn[k]);
        end
      end else if (ekind == 1) begin
        exp_vo = 1'b0;
        idxq = q.find_first_index with (item.id == k);
        if (idxq.size() > 0) begin
          e = q[idxq[0]];
          if (e.due <= ce_cnt) begin
            q.delete(idxq[0]);
            exp_vo = (e.due == ce_cnt);
            if (exp_vo) zmod[k] = e.z;
          end
        end
        if (exp_vo && zmod[k]) zsmod[k] = 1'b1;
        else if (sclr_s) zsmod[k] = 1'b0;
        n_cmp++;
        if (ovo[k] !== exp_vo) begin
          n_err++;
          $display("FAIL vo dut%0d ce=%0d: got %b, want %b", k, ce_cnt, ovo[k], exp_vo);
        end
        n_cmp++;
        if (oz[k] !== zmod[k] || ozn[k] !== ~zmod[k]) begin
          n_err++;
          $display("FAIL z_zn dut%0d ce=%0d: got z=%b zn=%b, want z=%b zn=%b",
                   k, ce_cnt, oz[k], ozn[k], zmod[k], ~zmod[k]);
        end
      end else if (ekind == 2) begin
        n_cmp++;
        if (ovo[k] !== hvo[k] || oz[k] !== hz[k] || ozn[k] !== hzn[k]) begin
          n_err++;
          $display("FAIL hold dut%0d: got vo=%b z=%b zn=%b, want vo=%b z=%b zn=%b",
                   k, ovo[k], oz[k], ozn[k], hvo[k], hz[k], hzn[k]);
        end
      end
`ifdef NR_STICKY_EN
      if (ekind != 3) begin
        n_cmp++;
        if (ozs[k] !== zsmod[k]) begin
          n_err++;
          $display("FAIL zs dut%0d: got %b, want %b", k, ozs[k], zsmod[k]);
        end
      end
`endif
      hvo[k] = ovo[k];
      hz[k]  = oz[k];
      hzn[k] = ozn[k];
    end
  end

  task automatic drive(input logic ce, input logic rst, input logic vi, input logic [2:0] m,
                       input logic [8:0] d9, input logic [9:0] d10);
    CE = ce; RST = rst; VI = vi; MODE = m; D9 = d9; D10 = d10;
    @(posedge CK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 3'd0, 9'h0, 10'h0);
  endtask

  task automatic test_reset;
    drive(1'b1, 1'b1, 1'b1, 3'd1, 9'h0, 10'h0);  // VI with RST is ignored
    drive(1'b0, 1'b1, 1'b0, 3'd1, 9'h0, 10'h0);  // RST wins over CE=0
    idle(5);
    n_cmp++;
    if (vo9 !== 1'b0 || z9 !== 1'b0 || zn9 !== 1'b1 || vo10 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: got vo9=%b z9=%b zn9=%b vo10=%b, want 0 0 1 0",
               vo9, z9, zn9, vo10);
    end
  endtask

  task automatic test_nor;
    drive(1'b1, 1'b0, 1'b1, 3'd1, 9'h000, 10'h000);
    drive(1'b1, 1'b0, 1'b1, 3'd1, 9'h100, 10'h200);
    idle(1);
    n_cmp++;
    if (vo9 !== 1'b1 || z9 !== 1'b1 || zn9 !== 1'b0) begin
      n_err++;
      $display("FAIL nor_zero: got vo=%b z=%b zn=%b, want 1 1 0", vo9, z9, zn9);
    end
    idle(1);
    n_cmp++;
    if (vo9 !== 1'b1 || z9 !== 1'b0 || zn9 !== 1'b1) begin
      n_err++;
      $display("FAIL nor_msb: got vo=%b z=%b zn=%b, want 1 0 1", vo9, z9, zn9);
    end
    idle(4);
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 1'b0, 1'b1, 3'd4, 9'h1FF, 10'h3FF);
    drive(1'b1, 1'b0, 1'b1, 3'd2, 9'h1FF, 10'h3FF);
    drive(1'b1, 1'b0, 1'b1, 3'd3, 9'h1FE, 10'h3FE);
    idle(1);
    n_cmp++;
    if (vo10 !== 1'b1 || z10 !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_xor: got vo=%b z=%b, want 1 0", vo10, z10);
    end
    idle(1);
    n_cmp++;
    if (vo10 !== 1'b1 || z10 !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_and: got vo=%b z=%b, want 1 1", vo10, z10);
    end
    idle(1);
    n_cmp++;
    if (vo10 !== 1'b1 || z10 !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_nand: got vo=%b z=%b, want 1 1", vo10, z10);
    end
    idle(3);
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'b0, 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 9'($urandom), 10'($urandom));
    end
    idle(5);
  endtask

  task automatic test_ce_stall;
    drive(1'b1, 1'b0, 1'b1, 3'd0, 9'h001, 10'h001);
    drive(1'b1, 1'b0, 1'b1, 3'd2, 9'h000, 10'h3FF);
    idle(1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 3'd5, 9'h0AA, 10'h155);
      n_cmp++;
      if (vo9 !== 1'b1 || z9 !== 1'b1) begin
        n_err++;
        $display("FAIL stall_hold: got vo=%b z=%b, want 1 1", vo9, z9);
      end
    end
    idle(1);
    n_cmp++;
    if (vo9 !== 1'b1 || z9 !== 1'b0 || zn9 !== 1'b1) begin
      n_err++;
      $display("FAIL stall_resume: got vo=%b z=%b zn=%b, want 1 0 1", vo9, z9, zn9);
    end
    idle(5);
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 1'b0, 1'b1, 3'd0, 9'h010, 10'h010);
    drive(1'b1, 1'b0, 1'b1, 3'd0, 9'h020, 10'h020);
    drive(1'b1, 1'b1, 1'b0, 3'd0, 9'h000, 10'h000);
    idle(5);
    n_cmp++;
    if (vo9 !== 1'b0 || z9 !== 1'b0 || zn9 !== 1'b1 ||
        vo10 !== 1'b0 || z10 !== 1'b0 || zn10 !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid: got vo9=%b z9=%b zn9=%b vo10=%b z10=%b zn10=%b, want 0 0 1 0 0 1",
               vo9, z9, zn9, vo10, z10, zn10);
    end
  endtask

`ifdef NR_STICKY_EN
  task automatic test_sticky;
    drive(1'b1, 1'b0, 1'b1, 3'd0, 9'h000, 10'h000);
    drive(1'b1, 1'b0, 1'b1, 3'd0, 9'h040, 10'h200);
    drive(1'b1, 1'b0, 1'b1, 3'd0, 9'h000, 10'h000);
    idle(4);
    n_cmp++;
    if (zs9 !== 1'b1) begin
      n_err++;
      $display("FAIL sticky_set: got %b, want 1", zs9);
    end
    SCLR = 1'b1;
    idle(1);
    SCLR = 1'b0;
    n_cmp++;
    if (zs9 !== 1'b0) begin
      n_err++;
      $display("FAIL sticky_clr: got %b, want 0", zs9);
    end
    drive(1'b1, 1'b0, 1'b1, 3'd0, 9'h001, 10'h001);
    idle(1);
    SCLR = 1'b1;
    idle(1);
    SCLR = 1'b0;
    n_cmp++;
    if (zs9 !== 1'b1) begin
      n_err++;
      $display("FAIL sticky_set_wins: got %b, want 1", zs9);
    end
    idle(2);
    SCLR = 1'b1;
    idle(1);
    SCLR = 1'b0;
    n_cmp++;
    if (zs9 !== 1'b0 || zs10 !== 1'b0) begin
      n_err++;
      $display("FAIL sticky_clr2: got zs9=%b zs10=%b, want 0 0", zs9, zs10);
    end
    idle(3);
  endtask
`endif

  initial begin
    RST = 1'b1; CE = 1'b0; VI = 1'b0; MODE = 3'd0; D9 = '0; D10 = '0;
`ifdef NR_STICKY_EN
    SCLR = 1'b0;
`endif
    test_reset();
    test_nor();
    test_back_to_back();
    test_ce_stall();
    test_reset_mid();
`ifdef NR_STICKY_EN
    test_sticky();
`endif
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL pending: got %0d outstanding results, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
